mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single memory bus between the instruction cache (ic) and data cache (dc).
//  Grants one owner at a time and routes bus request signals from the owner.
//  Steers bus_reqack/bus_respcyc only to the owner and watchdogs held grants.
//  Sits between the fetch/memory stage caches and the top-level bus port.
// PARAMETERS
//  BUS_DATA_WIDTH  64    bus request/response data width
//  BUS_TAG_WIDTH   13    bus tag width
//  HOLD_LIMIT      1024  max cycles a grant is held before err_timeout sets (>=2)
// PORTS
//  clk            in   1    clock
//  reset          in   1    synchronous, active-high reset
//  {ic,dc}_busreq   in   1    requester wants bus; level, held until granted
//  {ic,dc}_busidle  in   1    1-cycle pulse: owner's transaction fully complete
//  {ic,dc}_busgrant out  1    registered grant; at most one high
//  {ic,dc}_reqcyc   in   1    requester bus_reqcyc
//  {ic,dc}_req      in   BDW  requester bus_req data/address
//  {ic,dc}_reqtag   in   BTW  requester bus_reqtag
//  {ic,dc}_respack  in   1    requester bus_respack
//  {ic,dc}_reqack   out  1    bus_reqack gated to owner
//  {ic,dc}_respcyc  out  1    bus_respcyc gated to owner
//  bus_reqcyc/bus_req/bus_reqtag/bus_respack  out  1/BDW/BTW/1  muxed from owner, 0 if none
//  bus_reqack/bus_respcyc  in  1  from memory bus
//  owner          out  2    2'b00 none, 2'b01 ic, 2'b10 dc
//  err_timeout    out  1    sticky: a grant exceeded HOLD_LIMIT cycles
// BEHAVIOUR
//  - Reset: state IDLE; all grants, owner, bus_* outputs, *_reqack, *_respcyc and err_timeout = 0; hold counter = 0.
//  - FSM: IDLE -> GRANT_IC | GRANT_DC -> TURN -> IDLE.
//  - IDLE: sample reqs; winner's grant goes high the next cycle (1-cycle request-to-grant latency).
//  - IDLE with no req: stays IDLE.
//  - GRANT_x: grant held; owner's reqcyc/req/reqtag/respack drive bus_* combinationally.
//  - GRANT_x: bus_reqack/bus_respcyc drive only x_reqack/x_respcyc; other requester sees 0.
//  - GRANT_x exit: on x_busidle, grant drops next cycle and FSM enters TURN.
//  - busidle from a non-owner, or in IDLE/TURN, is ignored.
//  - TURN: exactly one dead cycle, no grant, bus_* = 0. Then IDLE, re-arbitrate.
//  - Owner dropping busreq without busidle does not release the grant; only busidle releases.
//  - Hold counter: clears on grant entry, saturates; err_timeout sets when count == HOLD_LIMIT.
//  - err_timeout does not force release; only reset clears it.
//  - Simultaneous ic_busreq & dc_busreq in IDLE: resolved by priority policy (CONFIGURATION).
//  - Reset mid-grant: grant drops the cycle after reset is sampled; no bus_* output is held.
//  - Bus response data/tag are not muxed; caches read bus_resp/bus_resptag directly.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: on tie, grant goes to the requester not granted last. last_owner resets to dc, so ic wins the first tie.
//  Not defined: fixed priority, dc always wins ties; ic may starve under continuous dc traffic.
// TESTING
//  - Reset: assert reset 3 cycles with both reqs high -> grants=0, owner=0, bus_reqcyc=0, err_timeout=0.
//  - Single ic: ic_busreq=1 at cycle 0 -> ic_busgrant=1 at 1, owner=01; bus_req==ic_req. ic_busidle at 5 -> grant 0 at 6, TURN at 6, IDLE at 7.
//  - Tie (both reqs held): fixed priority -> dc, then ic after TURN. With ARB_ROUND_ROBIN_EN, order alternates ic,dc,ic,dc over 4 grants.
//  - Routing: during dc grant, pulse bus_reqack and bus_respcyc -> dc_reqack/dc_respcyc=1, ic_reqack/ic_respcyc=0. Toggle ic_reqcyc -> bus_reqcyc unchanged.
//  - Watchdog: HOLD_LIMIT=8, grant ic, never pulse idle -> err_timeout=1 at cycle 9 after grant, grant remains 1, sticky until reset.
//  - Stray idle and reset: dc_busidle during ic grant -> no effect. Reset during grant -> grant 0 next cycle, state IDLE.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-way memory bus arbiter between instruction and data caches, with a grant hold watchdog.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed priority with dc winning ties.
module mem_bus_arbiter #(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13,
    parameter int unsigned HOLD_LIMIT     = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ic_busreq_i,
    input  logic                      dc_busreq_i,
    input  logic                      ic_busidle_i,
    input  logic                      dc_busidle_i,
    output logic                      ic_busgrant_o,
    output logic                      dc_busgrant_o,
    input  logic                      ic_reqcyc_i,
    input  logic [BUS_DATA_WIDTH-1:0] ic_req_i,
    input  logic [BUS_TAG_WIDTH-1:0]  ic_reqtag_i,
    input  logic                      ic_respack_i,
    input  logic                      dc_reqcyc_i,
    input  logic [BUS_DATA_WIDTH-1:0] dc_req_i,
    input  logic [BUS_TAG_WIDTH-1:0]  dc_reqtag_i,
    input  logic                      dc_respack_i,
    output logic                      ic_reqack_o,
    output logic                      ic_respcyc_o,
    output logic                      dc_reqack_o,
    output logic                      dc_respcyc_o,
    output logic                      bus_reqcyc_o,
    output logic [BUS_DATA_WIDTH-1:0] bus_req_o,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag_o,
    output logic                      bus_respack_o,
    input  logic                      bus_reqack_i,
    input  logic                      bus_respcyc_i,
    output logic [1:0]                owner_o,
    output logic                      err_timeout_o
);

    localparam int unsigned CNT_W = $clog2(HOLD_LIMIT + 1);
    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_IC   = 2'b01;
    localparam logic [1:0] OWN_DC   = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_IC,
        GRANT_DC,
        TURN
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [1:0]       owner_q, owner_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic             last_dc_q, last_dc_d;
`endif

    // State, hold counter, sticky error and owner registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            owner_q   <= OWN_NONE;
`ifdef ARB_ROUND_ROBIN_EN
            last_dc_q <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            owner_q   <= owner_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_dc_q <= last_dc_d;
`endif
        end
    end

    // Next-state: arbitration, release on owner busidle, watchdog
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_dc_d = last_dc_q;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (ic_busreq_i && dc_busreq_i) begin
`ifdef ARB_ROUND_ROBIN_EN
                    state_d = last_dc_q ? GRANT_IC : GRANT_DC;
`else
                    state_d = GRANT_DC;
`endif
                end else if (ic_busreq_i) begin
                    state_d = GRANT_IC;
                end else if (dc_busreq_i) begin
                    state_d = GRANT_DC;
                end
            end
            GRANT_IC, GRANT_DC: begin
                if (cnt_q == CNT_W'(HOLD_LIMIT)) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if ((state_q == GRANT_IC && ic_busidle_i) ||
                    (state_q == GRANT_DC && dc_busidle_i)) begin
                    state_d = TURN;
                end
            end
            TURN: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef ARB_ROUND_ROBIN_EN
        if (state_q == IDLE && state_d != IDLE) begin
            last_dc_d = (state_d == GRANT_DC);
        end
`endif
        owner_d = OWN_NONE;
        if (state_d == GRANT_IC) owner_d = OWN_IC;
        if (state_d == GRANT_DC) owner_d = OWN_DC;
    end

    assign ic_busgrant_o = owner_q[0];
    assign dc_busgrant_o = owner_q[1];
    assign owner_o       = owner_q;
    assign err_timeout_o = err_q;

    // Bus request mux and response-handshake steering follow the registered owner
    always_comb begin
        bus_reqcyc_o  = 1'b0;
        bus_req_o     = '0;
        bus_reqtag_o  = '0;
        bus_respack_o = 1'b0;
        ic_reqack_o   = 1'b0;
        ic_respcyc_o  = 1'b0;
        dc_reqack_o   = 1'b0;
        dc_respcyc_o  = 1'b0;
        if (owner_q == OWN_IC) begin
            bus_reqcyc_o  = ic_reqcyc_i;
            bus_req_o     = ic_req_i;
            bus_reqtag_o  = ic_reqtag_i;
            bus_respack_o = ic_respack_i;
            ic_reqack_o   = bus_reqack_i;
            ic_respcyc_o  = bus_respcyc_i;
        end else if (owner_q == OWN_DC) begin
            bus_reqcyc_o  = dc_reqcyc_i;
            bus_req_o     = dc_req_i;
            bus_reqtag_o  = dc_reqtag_i;
            bus_respack_o = dc_respack_i;
            dc_reqack_o   = bus_reqack_i;
            dc_respcyc_o  = bus_respcyc_i;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (HOLD_LIMIT = 8).
module tb_mem_bus_arbiter;

    localparam int unsigned BDW = 64;
    localparam int unsigned BTW = 13;

    logic           clk = 1'b0;
    logic           reset;
    logic           ic_busreq, dc_busreq, ic_busidle, dc_busidle;
    logic           ic_busgrant, dc_busgrant;
    logic           ic_reqcyc, dc_reqcyc, ic_respack, dc_respack;
    logic [BDW-1:0] ic_req, dc_req, bus_req;
    logic [BTW-1:0] ic_reqtag, dc_reqtag, bus_reqtag;
    logic           ic_reqack, ic_respcyc, dc_reqack, dc_respcyc;
    logic           bus_reqcyc, bus_respack, bus_reqack, bus_respcyc;
    logic [1:0]     owner;
    logic           err_timeout;

    int errors = 0;
    int checks = 0;

    mem_bus_arbiter #(
        .BUS_DATA_WIDTH(BDW),
        .BUS_TAG_WIDTH (BTW),
        .HOLD_LIMIT    (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ic_busreq_i  (ic_busreq),
        .dc_busreq_i  (dc_busreq),
        .ic_busidle_i (ic_busidle),
        .dc_busidle_i (dc_busidle),
        .ic_busgrant_o(ic_busgrant),
        .dc_busgrant_o(dc_busgrant),
        .ic_reqcyc_i  (ic_reqcyc),
        .ic_req_i     (ic_req),
        .ic_reqtag_i  (ic_reqtag),
        .ic_respack_i (ic_respack),
        .dc_reqcyc_i  (dc_reqcyc),
        .dc_req_i     (dc_req),
        .dc_reqtag_i  (dc_reqtag),
        .dc_respack_i (dc_respack),
        .ic_reqack_o  (ic_reqack),
        .ic_respcyc_o (ic_respcyc),
        .dc_reqack_o  (dc_reqack),
        .dc_respcyc_o (dc_respcyc),
        .bus_reqcyc_o (bus_reqcyc),
        .bus_req_o    (bus_req),
        .bus_reqtag_o (bus_reqtag),
        .bus_respack_o(bus_respack),
        .bus_reqack_i (bus_reqack),
        .bus_respcyc_i(bus_respcyc),
        .owner_o      (owner),
        .err_timeout_o(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset      = 1'b1;
        ic_busreq  = 1'b1;
        dc_busreq  = 1'b1;
        ic_busidle = 1'b0;
        dc_busidle = 1'b0;
        ic_reqcyc  = 1'b1;
        dc_reqcyc  = 1'b0;
        ic_respack = 1'b0;
        dc_respack = 1'b0;
        ic_req     = '0;
        dc_req     = '0;
        ic_reqtag  = '0;
        dc_reqtag  = '0;
        bus_reqack = 1'b0;
        bus_respcyc = 1'b0;

        // Reset held three cycles with both requests high
        repeat (3) tick();
        chk("rst_ic_grant", 64'(ic_busgrant), 64'd0);
        chk("rst_dc_grant", 64'(dc_busgrant), 64'd0);
        chk("rst_owner", 64'(owner), 64'd0);
        chk("rst_bus_reqcyc", 64'(bus_reqcyc), 64'd0);
        chk("rst_err", 64'(err_timeout), 64'd0);
        reset     = 1'b0;
        ic_busreq = 1'b0;
        dc_busreq = 1'b0;
        ic_reqcyc = 1'b0;
        tick();

        // Single ic transaction: grant at 1, idle at 5, TURN at 6, IDLE at 7, regrant at 8
        ic_busreq  = 1'b1;
        ic_req     = 64'hDEAD_BEEF_0123_4567;
        ic_reqtag  = 13'h1ABC;
        ic_reqcyc  = 1'b1;
        ic_respack = 1'b1;
        tick();
        chk("ic_grant_c1", 64'(ic_busgrant), 64'd1);
        chk("ic_dcgrant_c1", 64'(dc_busgrant), 64'd0);
        chk("ic_owner_c1", 64'(owner), 64'd1);
        chk("ic_bus_req", bus_req, 64'hDEAD_BEEF_0123_4567);
        chk("ic_bus_reqtag", 64'(bus_reqtag), 64'h1ABC);
        chk("ic_bus_reqcyc", 64'(bus_reqcyc), 64'd1);
        chk("ic_bus_respack", 64'(bus_respack), 64'd1);
        ic_busreq = 1'b0;
        repeat (4) tick();
        chk("ic_grant_held_c5", 64'(ic_busgrant), 64'd1);
        ic_busidle = 1'b1;
        tick();
        ic_busidle = 1'b0;
        chk("ic_grant_c6", 64'(ic_busgrant), 64'd0);
        chk("ic_owner_c6", 64'(owner), 64'd0);
        chk("turn_bus_req", bus_req, 64'd0);
        chk("turn_bus_reqcyc", 64'(bus_reqcyc), 64'd0);
        ic_busreq = 1'b1;
        tick();
        chk("idle_grant_c7", 64'(ic_busgrant), 64'd0);
        tick();
        chk("regrant_c8", 64'(ic_busgrant), 64'd1);
        ic_busreq  = 1'b0;
        ic_busidle = 1'b1;
        tick();
        ic_busidle = 1'b0;
        ic_reqcyc  = 1'b0;
        ic_respack = 1'b0;
        ic_req     = '0;
        ic_reqtag  = '0;
        tick();

        // Tie: last owner was ic, so dc wins under either policy
        ic_busreq = 1'b1;
        dc_busreq = 1'b1;
        tick();
        chk("tie1_dc_grant", 64'(dc_busgrant), 64'd1);
        chk("tie1_ic_grant", 64'(ic_busgrant), 64'd0);
        chk("tie1_owner", 64'(owner), 64'd2);

        // Routing during dc grant
        dc_req    = 64'h0123_4567_89AB_CDEF;
        dc_reqtag = 13'h0055;
        ic_reqcyc = 1'b1;
        #1;
        chk("rt_ic_reqcyc_blocked", 64'(bus_reqcyc), 64'd0);
        bus_reqack  = 1'b1;
        bus_respcyc = 1'b1;
        #1;
        chk("rt_dc_reqack", 64'(dc_reqack), 64'd1);
        chk("rt_dc_respcyc", 64'(dc_respcyc), 64'd1);
        chk("rt_ic_reqack", 64'(ic_reqack), 64'd0);
        chk("rt_ic_respcyc", 64'(ic_respcyc), 64'd0);
        dc_reqcyc = 1'b1;
        ic_reqcyc = 1'b0;
        #1;
        chk("rt_dc_reqcyc", 64'(bus_reqcyc), 64'd1);
        chk("rt_dc_req", bus_req, 64'h0123_4567_89AB_CDEF);
        chk("rt_dc_reqtag", 64'(bus_reqtag), 64'h0055);
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;

        // Release dc with both requests still held
        dc_busidle = 1'b1;
        tick();
        dc_busidle = 1'b0;
        chk("tie_turn_reqcyc", 64'(bus_reqcyc), 64'd0);
        chk("tie_turn_owner", 64'(owner), 64'd0);
        tick();
        tick();
`ifdef ARB_ROUND_ROBIN_EN
        chk("tie2_owner", 64'(owner), 64'd1);
        ic_busidle = 1'b1;
`else
        chk("tie2_owner", 64'(owner), 64'd2);
        dc_busidle = 1'b1;
`endif
        dc_busreq = 1'b0;
        tick();
        ic_busidle = 1'b0;
        dc_busidle = 1'b0;
        dc_reqcyc  = 1'b0;
        tick();
        tick();
        chk("tie3_ic_owner", 64'(owner), 64'd1);
        ic_busreq  = 1'b0;
        ic_busidle = 1'b1;
        tick();
        ic_busidle = 1'b0;
        tick();

        // Stray idle from non-owner, then reset mid-grant
        ic_busreq = 1'b1;
        tick();
        chk("stray_ic_grant", 64'(ic_busgrant), 64'd1);
        dc_busidle = 1'b1;
        tick();
        dc_busidle = 1'b0;
        chk("stray_ignored", 64'(ic_busgrant), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_grant", 64'(ic_busgrant), 64'd0);
        chk("rst_mid_owner", 64'(owner), 64'd0);
        tick();
        chk("post_rst_grant", 64'(ic_busgrant), 64'd1);
        ic_busreq  = 1'b0;
        ic_busidle = 1'b1;
        tick();
        ic_busidle = 1'b0;
        tick();

        // Watchdog: count reaches 8 at g+8, sticky error visible at g+9
        chk("wd_err_before", 64'(err_timeout), 64'd0);
        ic_busreq = 1'b1;
        tick();
        ic_busreq = 1'b0;
        chk("wd_grant_g", 64'(ic_busgrant), 64'd1);
        repeat (8) tick();
        chk("wd_err_g8", 64'(err_timeout), 64'd0);
        tick();
        chk("wd_err_g9", 64'(err_timeout), 64'd1);
        chk("wd_grant_kept", 64'(ic_busgrant), 64'd1);
        ic_busidle = 1'b1;
        tick();
        ic_busidle = 1'b0;
        chk("wd_released", 64'(ic_busgrant), 64'd0);
        chk("wd_sticky1", 64'(err_timeout), 64'd1);
        tick();
        chk("wd_sticky2", 64'(err_timeout), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("wd_reset_clear", 64'(err_timeout), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
